// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDU = 6'd3;
  localparam logic [5:0] OP_SUBU = 6'd4;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_SRL  = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SUBI = 6'd11;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd14;
  localparam logic [5:0] OP_SW   = 6'd15;
  localparam logic [5:0] OP_BEQ  = 6'd16;
  localparam logic [5:0] OP_BNE  = 6'd17;
  localparam logic [5:0] OP_BGT  = 6'd18;
  localparam logic [5:0] OP_BGE  = 6'd19;
  localparam logic [5:0] OP_BLT  = 6'd20;
  localparam logic [5:0] OP_BLE  = 6'd21;
  localparam logic [5:0] OP_SLTI = 6'd22;
  localparam logic [5:0] OP_JR   = 6'd24;
  localparam logic [5:0] OP_MUL  = 6'd26;
  localparam logic [5:0] OP_DIV  = 6'd27;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result handshake bundle between decode, the ALU and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [5:0]               op;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic [IMM_W-1:0]         imm;
  logic [$clog2(WIDTH)-1:0] shamt;
  logic [WIDTH-1:0]         pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         result;
  logic                     c_out;
  logic                     jump;
  logic                     err;

  modport master (
    output in_valid, op, a, b, imm, shamt, pc, out_ready,
    input  in_ready, out_valid, result, c_out, jump, err
  );

  modport slave (
    input  in_valid, op, a, b, imm, shamt, pc, out_ready,
    output in_ready, out_valid, result, c_out, jump, err
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// r_hi holds the upper product half or the remainder; r_lo the multiplier or quotient.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_c_out
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             r_busy;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH-1:0] w_div_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // One multiply or divide step from the current partial state.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};
    w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_opnd});
    w_div_sub = w_div_sh[WIDTH-1:0] - r_opnd;
    if (r_is_div) begin
      w_hi_nxt = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done   = r_busy && (r_cnt == CNT_W'(WIDTH));
  assign o_result = r_lo;
  assign o_c_out  = |r_hi;

  // Operand load, iteration counter and partial-state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_opnd   <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
      r_cnt    <= {CNT_W{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= i_a;
      r_opnd   <= i_b;
    end else if (o_done) begin
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
    end else begin
      r_busy   <= r_busy;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle datapath for the legacy opcodes plus an
// iterative multiply/divide engine, all results presented from registers.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_c_out;
  logic             r_jump;
  logic             r_err;

  logic [WIDTH-1:0] w_imm_x;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_tgt;
  logic             w_taken;
  logic             w_is_md;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;
  logic             w_md_c;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_jump;
  logic             w_err;

  assign w_imm_x    = WIDTH'(bus.imm);
  assign w_opb      = is_imm_op(bus.op) ? w_imm_x : bus.b;
  assign w_sum      = {1'b0, bus.a} + {1'b0, w_opb};
  assign w_diff     = {1'b0, bus.a} - {1'b0, w_opb};
  assign w_tgt      = {1'b0, bus.pc} + {1'b0, w_imm_x};
  assign w_pc4      = bus.pc + WIDTH'(3'd4);
  assign w_is_md    = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  // Zero divisor (and zero multiplier) finish on the single-cycle path.
  assign w_md_start = r_in_ready && bus.in_valid && w_is_md && (bus.b != {WIDTH{1'b0}});

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_start),
    .i_is_div (bus.op == OP_DIV),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_done   (w_md_done),
    .o_result (w_md_result),
    .o_c_out  (w_md_c)
  );

  // Unsigned branch condition.
  always_comb begin
    w_taken = 1'b0;
    case (bus.op)
      OP_BEQ:  w_taken = (bus.a == bus.b);
      OP_BNE:  w_taken = (bus.a != bus.b);
      OP_BGT:  w_taken = (bus.a >  bus.b);
      OP_BGE:  w_taken = (bus.a >= bus.b);
      OP_BLT:  w_taken = (bus.a <  bus.b);
      OP_BLE:  w_taken = (bus.a <= bus.b);
      default: w_taken = 1'b0;
    endcase
  end

  // Single-cycle result and flags for the opcode presented.
  always_comb begin
    w_res  = {WIDTH{1'b0}};
    w_c    = 1'b0;
    w_jump = 1'b0;
    w_err  = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADDU, OP_ADDI: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
      end
      OP_SUB, OP_SUBU, OP_SUBI: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
      end
      OP_AND, OP_ANDI:  w_res = bus.a & w_opb;
      OP_OR, OP_ORI:    w_res = bus.a | w_opb;
      OP_SLL:           w_res = bus.a << bus.shamt;
      OP_SRL:           w_res = bus.a >> bus.shamt;
      OP_SLT, OP_SLTI:  w_res = WIDTH'(w_diff[WIDTH]);
      OP_LW, OP_SW:     w_res = w_sum[WIDTH-1:0];
      OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
        if (w_taken) begin
          w_res  = w_tgt[WIDTH-1:0];
          w_c    = w_tgt[WIDTH];
          w_jump = 1'b1;
        end else begin
          w_res  = w_pc4;
          w_c    = 1'b0;
          w_jump = 1'b0;
        end
      end
      OP_JR: begin
        w_res  = bus.a;
        w_jump = 1'b1;
      end
      OP_MUL:  w_res = {WIDTH{1'b0}};
      OP_DIV: begin
        w_res = {WIDTH{1'b1}};
        w_c   = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_c_out     <= 1'b0;
      r_jump      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_md_start) begin
              r_state <= ITER;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_c_out     <= w_c;
              r_jump      <= w_jump;
              r_err       <= w_err;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ITER: begin
          if (w_md_done) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_md_result;
            r_c_out     <= w_md_c;
            r_jump      <= 1'b0;
            r_err       <= 1'b0;
          end else begin
            r_state <= ITER;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.c_out     = r_c_out;
  assign bus.jump      = r_jump;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        j;
    logic        e;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(32), .IMM_W(16)) bus32 ();
  alu_seq_if #(.WIDTH(8),  .IMM_W(8))  bus8  ();

  alu_seq #(.WIDTH(32), .IMM_W(16)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_seq #(.WIDTH(8),  .IMM_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  // Reference behaviour written directly from the opcode table.
  function automatic exp_t model32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [15:0] imm, input logic [4:0] sh, input logic [31:0] pc);
    exp_t e; logic [63:0] w; logic [31:0] bi; logic tk;
    e.res = 32'd0; e.c = 1'b0; e.j = 1'b0; e.e = 1'b0; e.lat = 1;
    bi = {16'd0, imm};
    case (op)
      6'd1, 6'd3:   begin w = {32'd0, a} + {32'd0, b};  e.res = w[31:0]; e.c = w[32]; end
      6'd10:        begin w = {32'd0, a} + {32'd0, bi}; e.res = w[31:0]; e.c = w[32]; end
      6'd2, 6'd4:   begin e.res = a - b;  e.c = (a < b);  end
      6'd11:        begin e.res = a - bi; e.c = (a < bi); end
      6'd5:  e.res = a & b;
      6'd12: e.res = a & bi;
      6'd6:  e.res = a | b;
      6'd13: e.res = a | bi;
      6'd7:  e.res = a << sh;
      6'd8:  e.res = a >> sh;
      6'd9:  e.res = (a < b)  ? 32'd1 : 32'd0;
      6'd22: e.res = (a < bi) ? 32'd1 : 32'd0;
      6'd14, 6'd15: e.res = a + bi;
      6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21: begin
        case (op)
          6'd16:   tk = (a == b);
          6'd17:   tk = (a != b);
          6'd18:   tk = (a > b);
          6'd19:   tk = (a >= b);
          6'd20:   tk = (a < b);
          default: tk = (a <= b);
        endcase
        if (tk) begin w = {32'd0, pc} + {32'd0, bi}; e.res = w[31:0]; e.c = w[32]; e.j = 1'b1; end
        else    e.res = pc + 32'd4;
      end
      6'd24: begin e.res = a; e.j = 1'b1; end
      6'd26: if (b != 32'd0) begin w = {32'd0, a} * {32'd0, b}; e.res = w[31:0]; e.c = (w[63:32] != 32'd0); e.lat = 33; end
      6'd27: if (b == 32'd0) begin e.res = 32'hFFFF_FFFF; e.c = 1'b1; end
             else begin e.res = a / b; e.c = ((a % b) != 32'd0); e.lat = 33; end
      default: e.e = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [4:0] sh, input logic [31:0] pc);
    sb.push_back(model32(op, a, b, imm, sh, pc));
    @(negedge clk);
    n_tests++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_in_ready: got %b want 1", bus32.in_ready);
    end
    bus32.in_valid = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    bus32.imm = imm; bus32.shamt = sh; bus32.pc = pc;
    @(posedge clk); #1;
    // Scramble inputs after accept; the DUT must have latched them.
    bus32.in_valid = 1'b0; bus32.op = 6'($urandom); bus32.a = $urandom; bus32.b = $urandom;
    bus32.imm = 16'($urandom); bus32.shamt = 5'($urandom); bus32.pc = $urandom;
  endtask

  task automatic collect32(input string name, input int hold);
    exp_t e; int lat; bit rdy_bad; bit hold_bad;
    lat = 0; rdy_bad = 1'b0; hold_bad = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (bus32.in_ready !== 1'b0) rdy_bad = 1'b1;
      if (bus32.out_valid === 1'b1) break;
    end
    n_tests++;
    if (bus32.out_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL %s_timeout: out_valid=%b queued=%0d", name, bus32.out_valid, sb.size());
      sb.delete(); return;
    end
    e = sb.pop_front();
    n_tests++;
    if (bus32.result !== e.res) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, bus32.result, e.res); end
    n_tests++;
    if (bus32.c_out !== e.c) begin n_fail++; $display("FAIL %s_c_out: got %b want %b", name, bus32.c_out, e.c); end
    n_tests++;
    if (bus32.jump !== e.j || bus32.err !== e.e) begin
      n_fail++; $display("FAIL %s_flags: jump/err got %b/%b want %b/%b", name, bus32.jump, bus32.err, e.j, e.e);
    end
    n_tests++;
    if (lat != e.lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat); end
    n_tests++;
    if (rdy_bad) begin n_fail++; $display("FAIL %s_busy_in_ready: got 1 want 0", name); end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        bus32.in_valid = 1'b1; bus32.op = 6'd1; bus32.a = $urandom; bus32.b = $urandom;
        @(posedge clk); #1;
        if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 || bus32.result !== e.res ||
            bus32.c_out !== e.c || bus32.jump !== e.j || bus32.err !== e.e) hold_bad = 1'b1;
      end
      bus32.in_valid = 1'b0;
      n_tests++;
      if (hold_bad) begin n_fail++; $display("FAIL %s_hold: outputs changed or input accepted, got 1 want 0", name); end
    end
    @(negedge clk); bus32.out_ready = 1'b1;
    @(posedge clk); #1; bus32.out_ready = 1'b0;
    n_tests++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release: out_valid/in_ready got %b/%b want 0/1", name, bus32.out_valid, bus32.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: in_ready/out_valid got %b/%b want 1/0", bus32.in_ready, bus32.out_valid);
    end
    n_tests++;
    if (bus32.result !== 32'd0 || bus32.c_out !== 1'b0 || bus32.jump !== 1'b0 || bus32.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b/%b/%b want 0/0/0/0", bus32.result, bus32.c_out, bus32.jump, bus32.err);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith();
    drive32(6'd1, 32'hFFFF_FFFF, 32'd1, 16'd0, 5'd0, 32'd0);      collect32("add_wrap", 0);
    drive32(6'd2, 32'd3, 32'd5, 16'd0, 5'd0, 32'd0);              collect32("sub_borrow", 0);
    drive32(6'd10, 32'h1234_0000, 32'd0, 16'hBEEF, 5'd0, 32'd0);  collect32("addi", 0);
    drive32(6'd7, 32'h8000_0001, 32'd0, 16'd0, 5'd4, 32'd0);      collect32("sll", 0);
    drive32(6'd8, 32'h8000_0000, 32'd0, 16'd0, 5'd31, 32'd0);     collect32("srl", 0);
    drive32(6'd22, 32'd5, 32'd0, 16'd6, 5'd0, 32'd0);             collect32("slti", 0);
    drive32(6'd23, 32'd5, 32'd6, 16'd0, 5'd0, 32'd0);             collect32("illegal", 0);
  endtask

  task automatic test_branch();
    drive32(6'd21, 32'd7, 32'd7, 16'h0020, 5'd0, 32'h100);        collect32("ble_taken", 0);
    drive32(6'd20, 32'd7, 32'd7, 16'h0020, 5'd0, 32'h100);        collect32("blt_not", 0);
    drive32(6'd16, 32'd9, 32'd9, 16'hFFFF, 5'd0, 32'hFFFF_FFF0);  collect32("beq_carry", 0);
    drive32(6'd24, 32'hCAFE_0000, 32'd1, 16'd0, 5'd0, 32'd0);     collect32("jr", 0);
  endtask

  task automatic test_muldiv();
    drive32(6'd26, 32'h0001_0000, 32'h0001_0000, 16'd0, 5'd0, 32'd0); collect32("mul_ovf", 5);
    drive32(6'd27, 32'd100, 32'd7, 16'd0, 5'd0, 32'd0);               collect32("div_rem", 0);
    drive32(6'd27, 32'd1234, 32'd0, 16'd0, 5'd0, 32'd0);              collect32("div_zero", 0);
    drive32(6'd26, 32'd12345, 32'd678, 16'd0, 5'd0, 32'd0);           collect32("mul_small", 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    drive32(6'd26, 32'hDEAD_BEEF, 32'h0000_1234, 16'd0, 5'd0, 32'd0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.result !== 32'd0 || bus32.c_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: in_ready/out_valid/result/c_out got %b/%b/%h/%b want 1/0/0/0",
                         bus32.in_ready, bus32.out_valid, bus32.result, bus32.c_out);
    end
    sb.delete();
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus32.out_valid !== 1'b0) seen = 1'b1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL reset_abort: out_valid got 1 want 0"); end
    drive32(6'd26, 32'd1000, 32'd1000, 16'd0, 5'd0, 32'd0); collect32("mul_after_reset", 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [0:12];
    ops = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd9, 6'd11, 6'd13, 6'd15, 6'd17, 6'd19, 6'd26, 6'd27, 6'd63};
    for (int i = 0; i < 16; i++) begin
      drive32(ops[$urandom_range(0, 12)], $urandom, 32'($urandom_range(0, 300)), 16'($urandom),
              5'($urandom), $urandom);
      collect32("random", 0);
    end
  endtask

  task automatic run8(input string name, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] res, input logic c, input int lat_exp);
    exp_t e; int lat;
    e.res = {24'd0, res}; e.c = c; e.j = 1'b0; e.e = 1'b0; e.lat = lat_exp;
    sb.push_back(e);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    lat = 0;
    while (lat < 40) begin @(posedge clk); #1; lat++; if (bus8.out_valid === 1'b1) break; end
    e = sb.pop_front();
    n_tests++;
    if (bus8.out_valid !== 1'b1 || bus8.result !== e.res[7:0] || bus8.c_out !== e.c || lat != e.lat) begin
      n_fail++; $display("FAIL %s: result/c_out/latency got %h/%b/%0d want %h/%b/%0d",
                         name, bus8.result, bus8.c_out, lat, e.res[7:0], e.c, e.lat);
    end
    @(negedge clk); bus8.out_ready = 1'b1;
    @(posedge clk); #1; bus8.out_ready = 1'b0;
  endtask

  task automatic test_width8();
    run8("w8_add_wrap", 6'd1,  8'hFF, 8'h01, 8'h00, 1'b1, 1);
    run8("w8_mul_ovf",  6'd26, 8'h10, 8'h10, 8'h00, 1'b1, 9);
    run8("w8_mul",      6'd26, 8'd13, 8'd11, 8'h8F, 1'b0, 9);
    run8("w8_div",      6'd27, 8'd200, 8'd9, 8'd22, 1'b1, 9);
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.op = 6'd0; bus32.a = 32'd0; bus32.b = 32'd0;
    bus32.imm = 16'd0; bus32.shamt = 5'd0; bus32.pc = 32'd0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.op = 6'd0; bus8.a = 8'd0; bus8.b = 8'd0;
    bus8.imm = 8'd0; bus8.shamt = 3'd0; bus8.pc = 8'd0;
    test_reset();
    test_arith();
    test_branch();
    test_muldiv();
    test_reset_mid();
    test_random();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's single-cycle ALU. Executes the existing 6-bit opcode set (arithmetic, logic, shifts, compares, branch-target resolution) with registered outputs, and adds iterative unsigned multiply and divide. Sits between decode/register-read and writeback/PC-update. Uses valid/ready handshakes on both sides so multi-cycle operations can stall the pipeline.

## Interface
Parameters:
- WIDTH, 32, datapath width (≥8, power of two)
- IMM_W, 16, immediate width; zero-extended to WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept (high only in IDLE)
- op  in  6  opcode (codebase encoding, below)
- a, b  in  WIDTH  source operands
- imm  in  IMM_W  immediate
- shamt  in  $clog2(WIDTH)  shift amount
- pc  in  WIDTH  PC of the instruction
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result / branch target
- c_out  out  1  carry/borrow/overflow flag
- jump  out  1  branch/jump taken
- err  out  1  illegal opcode

## Operation
- Accept on the rising edge where in_valid && in_ready; op and operands are sampled then. Later input changes are ignored.
- States: IDLE → (single-cycle op) DONE; IDLE → (MUL/DIV, b≠0) ITER → DONE after WIDTH iterations; DONE → IDLE on out_ready.
- ADD 1 / ADDU 3: a+b, c_out = carry out. SUB 2 / SUBU 4: a−b, c_out = borrow (a<b unsigned).
- AND 5, OR 6: c_out = 0. SLL 7 / SRL 8: a shifted logically by shamt.
- SLT 9: result = (a<b unsigned) ? 1 : 0.
- ADDI 10 / SUBI 11 / ANDI 12 / ORI 13 / SLTI 22: same as the register forms, with b replaced by zext(imm).
- LW 14 / SW 15: result = a + zext(imm), c_out = 0.
- Branches, all compares unsigned: BEQ 16 (a==b), BNE 17 (a!=b), BGT 18 (a>b), BGE 19 (a>=b), BLT 20 (a<b), BLE 21 (a<=b).
  - Taken: jump=1, result = pc+zext(imm), c_out = carry of that add.
  - Not taken: jump=0, result = pc+4, c_out = 0.
- JR 24: result = a, jump = 1, c_out = 0.
- MUL 26: shift-add over WIDTH cycles. result = low WIDTH bits of a*b. c_out = 1 iff high half ≠ 0.
- DIV 27: restoring division over WIDTH cycles. result = a/b unsigned. c_out = 1 iff remainder ≠ 0.
  - Divide by zero: result = all ones, c_out = 1, completes single-cycle.
- Any other opcode: result = 0, c_out = 0, jump = 0, err = 1, single-cycle.
- jump = 0 and err = 0 for all non-branch legal ops.
- All arithmetic is modulo 2^WIDTH. Wrap-around is not an error.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready 1, out_valid 0, result 0, c_out 0, jump 0, err 0, iteration counter 0.
- Single-cycle ops: accepted at edge k, out_valid=1 with result from edge k+1 onward.
- MUL/DIV: accepted at edge k, out_valid=1 from edge k+WIDTH+1. in_ready = 0 throughout.
- result, c_out, jump, err are held stable while out_valid && !out_ready.
- out_valid drops on the edge after an out_ready handshake. in_ready rises on that same edge.
- No accept in the same cycle as the output handshake; maximum throughput is 1 op per 2 cycles.
- Reset during ITER or DONE aborts the operation. No output is produced for it.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_DIV, existing numbering, plus OP_MUL=26, OP_DIV=27)
  - state enum {IDLE, ITER, DONE}
- One sub-module: alu_muldiv_iter.
  - Iterative shift-add multiplier / restoring divider, WIDTH-parametrised.
  - start/done interface.
  - Contains the counter and the partial product / remainder registers.
- Top level holds the FSM, output registers, and the combinational single-cycle datapath.

## Test plan
- ADD a=0xFFFFFFFF b=1 → result 0, c_out 1, out_valid 1 cycle after accept. SUB 3−5 → 0xFFFFFFFE, c_out 1.
- BLE a=b=7, pc=0x100, imm=0x20 → jump 1, result 0x120. BLT same operands → jump 0, result 0x104.
- MUL 0x10000×0x10000 (WIDTH=32) → result 0, c_out 1, out_valid exactly 33 cycles after accept, in_ready low until the handshake.
- DIV 100/7 → result 14, c_out 1 after 33 cycles. DIV x/0 → 0xFFFFFFFF, c_out 1, after 1 cycle.
- Hold out_ready=0 for 5 cycles after done → outputs stable, in_ready 0, new in_valid ignored. Then out_ready=1 → out_valid 0, in_ready 1 next edge.
- Assert rst mid-MUL → all outputs at reset values immediately. Next op accepted and completes normally. Repeat ADD/MUL at WIDTH=8: 0xFF+1 → 0 with c_out 1.
